// File: rtl/fdiv_pkg.sv
// Shared types and constants for the single-precision divide sequencer.
package fdiv_pkg;

  localparam int          EXP_W    = 8;
  localparam int          FRAC_W   = 23;
  localparam int          EXP_BIAS = 127;
  localparam int          EXP_MAX  = 255;
  localparam logic [31:0] QNAN     = 32'h7FC00000;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_LOAD,
    S_WAIT,
    S_DONE
  } state_e;

  // Exception flags travel together; at most one is ever set.
  typedef struct packed {
    logic invalid;
    logic div_by_zero;
    logic overflow;
    logic underflow;
  } flags_t;

endpackage

// File: rtl/fdiv_sequencer_fp_classify.sv
// Combinational IEEE-754 single classifier; denormals count as zero.
module fp_classify
  import fdiv_pkg::*;
(
  input  logic [31:0]      op,
  output logic             is_zero,
  output logic             is_inf,
  output logic             is_nan,
  output logic [EXP_W-1:0] exponent
);

  logic frac_nz;

  // Field decode: exponent 0 flushes to zero, all-ones splits on the fraction.
  always_comb begin
    exponent = op[FRAC_W +: EXP_W];
    frac_nz  = |op[FRAC_W-1:0];
    is_zero  = (exponent == '0);
    is_inf   = (exponent == EXP_W'(EXP_MAX)) && !frac_nz;
    is_nan   = (exponent == EXP_W'(EXP_MAX)) && frac_nz;
  end

endmodule

// File: rtl/fdiv_sequencer.sv
// Front-end sequencer for the Newton-Raphson divider: captures operands,
// resolves special cases locally, otherwise runs the fixed-latency divider.
module fdiv_sequencer
  import fdiv_pkg::*;
#(
  parameter int LATENCY = 40,
  parameter int CNT_W   = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] a_in,
  input  logic [31:0] b_in,
  output logic        busy,
  output logic        done,
  output logic [31:0] result,
  output logic        invalid,
  output logic        div_by_zero,
  output logic        overflow,
  output logic        underflow,
  output logic        div_en,
  output logic        div_load,
  output logic [31:0] div_n,
  output logic [31:0] div_d,
  input  logic [31:0] div_result
);

  state_e             state_q, state_d;
  logic [31:0]        opa_q, opa_d;
  logic [31:0]        opb_q, opb_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [31:0]        res_q, res_d;
  flags_t             flags_q, flags_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               div_en_q, div_en_d;
  logic               div_load_q, div_load_d;

  logic               a_zero, a_inf, a_nan;
  logic               b_zero, b_inf, b_nan;
  logic [EXP_W-1:0]   a_exp, b_exp;
  logic               sign;
  logic signed [9:0]  est;

  // The divider supplies the magnitude; the sign is always recomputed here.
  logic               unused_div_sign;
  assign unused_div_sign = div_result[31];

  fp_classify u_cls_a (
    .op       (opa_q),
    .is_zero  (a_zero),
    .is_inf   (a_inf),
    .is_nan   (a_nan),
    .exponent (a_exp)
  );

  fp_classify u_cls_b (
    .op       (opb_q),
    .is_zero  (b_zero),
    .is_inf   (b_inf),
    .is_nan   (b_nan),
    .exponent (b_exp)
  );

  // Result sign and biased exponent estimate; 10 bits signed spans -128..382.
  always_comb begin
    sign = opa_q[31] ^ opb_q[31];
    est  = $signed({2'b00, a_exp}) - $signed({2'b00, b_exp}) + 10'sd127;
  end

  // Next-state, operand capture, special-case resolution and output decode.
  always_comb begin
    state_d    = state_q;
    opa_d      = opa_q;
    opb_d      = opb_q;
    cnt_d      = cnt_q;
    res_d      = res_q;
    flags_d    = flags_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          opa_d   = a_in;
          opb_d   = b_in;
          flags_d = '0;
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        state_d = S_DONE;
        if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
          res_d           = QNAN;
          flags_d.invalid = 1'b1;
        end else if (b_zero && !a_inf) begin
          res_d               = {sign, 8'hFF, 23'h0};
          flags_d.div_by_zero = 1'b1;
        end else if (a_inf) begin
          res_d = {sign, 8'hFF, 23'h0};
        end else if (a_zero || b_inf) begin
          res_d = {sign, 31'h0};
        end else if (est > 10'sd254) begin
          res_d            = {sign, 8'hFF, 23'h0};
          flags_d.overflow = 1'b1;
        end else if (est < 10'sd1) begin
          res_d             = {sign, 31'h0};
          flags_d.underflow = 1'b1;
        end else begin
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        cnt_d   = CNT_W'(LATENCY - 1);
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (cnt_q == '0) begin
          res_d   = {sign, div_result[30:0]};
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Outputs are decoded from the next state so they register in step with it.
    busy_d     = (state_d != S_IDLE);
    done_d     = (state_d == S_DONE);
    div_load_d = (state_d == S_LOAD);
    div_en_d   = (state_d == S_LOAD) || (state_d == S_WAIT);
  end

  // Single state register; reset drops div_en and discards in-flight work.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      opa_q      <= '0;
      opb_q      <= '0;
      cnt_q      <= '0;
      res_q      <= '0;
      flags_q    <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      div_en_q   <= 1'b0;
      div_load_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      opa_q      <= opa_d;
      opb_q      <= opb_d;
      cnt_q      <= cnt_d;
      res_q      <= res_d;
      flags_q    <= flags_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      div_en_q   <= div_en_d;
      div_load_q <= div_load_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign result      = res_q;
  assign invalid     = flags_q.invalid;
  assign div_by_zero = flags_q.div_by_zero;
  assign overflow    = flags_q.overflow;
  assign underflow   = flags_q.underflow;
  assign div_en      = div_en_q;
  assign div_load    = div_load_q;
  assign div_n       = opa_q;
  assign div_d       = opb_q;

endmodule

// File: tb/tb_fdiv_sequencer.sv
// Randomized bench for fdiv_sequencer with a cycle-indexed reference model
// and a mock fixed-latency divider.
module tb_fdiv_sequencer;

  localparam int LAT = 40;
  localparam int CW  = 6;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [31:0] a_in = '0, b_in = '0, div_result = '0;
  logic        busy, done, invalid, div_by_zero, overflow, underflow;
  logic        div_en, div_load;
  logic [31:0] result, div_n, div_d;

  fdiv_sequencer #(.LATENCY(LAT), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .start(start), .a_in(a_in), .b_in(b_in),
    .busy(busy), .done(done), .result(result), .invalid(invalid),
    .div_by_zero(div_by_zero), .overflow(overflow), .underflow(underflow),
    .div_en(div_en), .div_load(div_load), .div_n(div_n), .div_d(div_d),
    .div_result(div_result)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int total = 0, bad = 0;

  function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc, act, exp);
    end
  endfunction

  // Reference: {special, {invalid,dbz,ovf,unf}, result}; normal path returns
  // only the sign in the result field.
  function automatic logic [36:0] ref_div(input logic [31:0] a, input logic [31:0] b);
    int ea = int'(a[30:23]);
    int eb = int'(b[30:23]);
    bit sg = a[31] ^ b[31];
    bit az = (ea == 0), bz = (eb == 0);
    bit ai = (ea == 255) && (a[22:0] == 0), bi = (eb == 255) && (b[22:0] == 0);
    bit an = (ea == 255) && (a[22:0] != 0), bn = (eb == 255) && (b[22:0] != 0);
    int est = ea - eb + 127;
    if (an || bn || (az && bz) || (ai && bi)) return {1'b1, 4'b1000, 32'h7FC00000};
    if (bz && !ai) return {1'b1, 4'b0100, sg, 8'hFF, 23'h0};
    if (ai)        return {1'b1, 4'b0000, sg, 8'hFF, 23'h0};
    if (az || bi)  return {1'b1, 4'b0000, sg, 31'h0};
    if (est > 254) return {1'b1, 4'b0010, sg, 8'hFF, 23'h0};
    if (est < 1)   return {1'b1, 4'b0001, sg, 31'h0};
    return {1'b0, 4'b0000, sg, 31'h0};
  endfunction

  // Model state, all in absolute cycle numbers.
  bit          act = 0, nrm = 0;
  int          s = 0, dc = 0, ld = -1000;
  logic [31:0] mq = '0, next_q = '0, er = '0, hr = '0;
  logic [3:0]  ef = '0, hf = '0;

  // Mock divider, per-cycle compare and model update, all on the falling edge.
  always @(negedge clk) begin
    logic [36:0] r;
    bit was;
    if (div_load) ld = cyc;
    div_result = (cyc == ld + LAT) ? mq : ~mq;

    if (cyc >= 1) begin
      if (act) begin
        chk("busy", busy, 1);
        chk("done", done, cyc == dc);
        chk("div_load", div_load, nrm && cyc == s + 2);
        chk("div_en", div_en, nrm && cyc >= s + 2 && cyc <= s + LAT + 2);
        if (cyc == dc) begin
          chk("result", result, er);
          chk("flags", {invalid, div_by_zero, overflow, underflow}, ef);
        end else begin
          chk("flags_busy", {invalid, div_by_zero, overflow, underflow}, 4'b0);
        end
      end else begin
        chk("idle_busy", busy, 0);
        chk("idle_done", done, 0);
        chk("idle_div_en", div_en, 0);
        chk("idle_div_load", div_load, 0);
        chk("held_result", result, hr);
        chk("held_flags", {invalid, div_by_zero, overflow, underflow}, hf);
      end
    end

    was = act;
    if (act && cyc == dc) begin
      act = 0; hr = er; hf = ef;
    end
    if (rst) begin
      act = 0; hr = '0; hf = '0; ld = -1000;
    end else if (!was && start) begin
      r   = ref_div(a_in, b_in);
      act = 1;
      s   = cyc;
      nrm = !r[36];
      mq  = next_q;
      ef  = r[35:32];
      er  = nrm ? {r[31], mq[30:0]} : r[31:0];
      dc  = nrm ? s + LAT + 3 : s + 2;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (act && n < 300) begin
      tick();
      n++;
    end
    if (act) begin
      total++; bad++;
      $display("FAIL wait_idle timeout cyc=%0d got=busy want=idle", cyc);
    end
    tick();
  endtask

  task automatic go(input logic [31:0] a, input logic [31:0] b, input logic [31:0] q);
    next_q = q; a_in = a; b_in = b; start = 1'b1;
    tick();
    start = 1'b0; a_in = $urandom; b_in = $urandom;
    wait_idle();
  endtask

  function automatic logic [31:0] gen_op();
    logic [31:0] v = $urandom;
    case ($urandom % 8)
      0: v[30:23] = 8'd0;
      1: begin v[30:23] = 8'hFF; v[22:0] = '0; end
      2: begin v[30:23] = 8'hFF; v[0] = 1'b1; end
      3: v[30:23] = 8'($urandom_range(200, 254));
      4: v[30:23] = 8'($urandom_range(1, 50));
      default: v[30:23] = 8'($urandom_range(1, 254));
    endcase
    return v;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog cyc=%0d got=running want=finished", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    // Hand-computed pins on the reference model.
    chk("pin_norm", ref_div(32'h40C00000, 32'h40000000), {1'b0, 4'b0000, 32'h00000000});
    chk("pin_dbz",  ref_div(32'hBF800000, 32'h00000000), {1'b1, 4'b0100, 32'hFF800000});
    chk("pin_00",   ref_div(32'h00000000, 32'h00000000), {1'b1, 4'b1000, 32'h7FC00000});
    chk("pin_ii",   ref_div(32'h7F800000, 32'hFF800000), {1'b1, 4'b1000, 32'h7FC00000});
    chk("pin_ovf",  ref_div(32'h7F000000, 32'h00800000), {1'b1, 4'b0010, 32'h7F800000});
    chk("pin_unf",  ref_div(32'h00800000, 32'h7F000000), {1'b1, 4'b0001, 32'h00000000});
    chk("pin_inff", ref_div(32'hFF800000, 32'h40000000), {1'b1, 4'b0000, 32'hFF800000});
    chk("pin_finf", ref_div(32'h3F800000, 32'hFF800000), {1'b1, 4'b0000, 32'h80000000});
    chk("pin_den",  ref_div(32'h00000001, 32'h3F800000), {1'b1, 4'b0000, 32'h00000000});

    repeat (3) tick();
    rst = 1'b0;
    tick();

    // Directed cases.
    go(32'h40C00000, 32'h40000000, 32'h40400000);
    chk("lit_norm", {result, invalid, div_by_zero, overflow, underflow}, {32'h40400000, 4'b0});
    go(32'hBF800000, 32'h00000000, 32'h12345678);
    chk("lit_dbz", {result, div_by_zero}, {32'hFF800000, 1'b1});
    go(32'h00000000, 32'h00000000, 32'h0);
    chk("lit_inv00", {result, invalid}, {32'h7FC00000, 1'b1});
    go(32'h7F800000, 32'hFF800000, 32'h0);
    chk("lit_invii", {result, invalid}, {32'h7FC00000, 1'b1});
    go(32'h7F000000, 32'h00800000, 32'h0);
    chk("lit_ovf", {result, overflow}, {32'h7F800000, 1'b1});
    go(32'h00800000, 32'h7F000000, 32'h0);
    chk("lit_unf", {result, underflow}, {32'h00000000, 1'b1});

    // Starts while busy, including the DONE cycle, are ignored.
    next_q = 32'h40400000; a_in = 32'h40C00000; b_in = 32'h40000000; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    a_in = 32'h3F800000; b_in = 32'h00000000; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (LAT - 3) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_idle();
    chk("lit_busy_res", result, 32'h40400000);

    // Reset in the middle of the wait.
    next_q = 32'h40400000; a_in = 32'h40C00000; b_in = 32'h40000000; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (9) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("lit_rst", {busy, div_en, done, result}, {3'b000, 32'h0});
    wait_idle();
    go(32'h40C00000, 32'h40000000, 32'h40400000);
    chk("lit_after_rst", result, 32'h40400000);

    // Random traffic with stray starts and occasional resets.
    for (int t = 0; t < 80; t++) begin
      go_rand();
    end

    repeat (3) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  task automatic go_rand();
    int n = 0;
    next_q = $urandom; a_in = gen_op(); b_in = gen_op(); start = 1'b1;
    tick();
    start = 1'b0;
    while (act && n < 300) begin
      start = ($urandom % 4 == 0);
      a_in = gen_op(); b_in = gen_op();
      rst = ($urandom % 80 == 0);
      tick();
      rst = 1'b0;
      n++;
    end
    start = 1'b0;
    wait_idle();
    repeat ($urandom % 3) tick();
  endtask

endmodule
